pattern_serializer: RTL and testbench
=====================================

# pattern_serializer

Parallel-to-serial stage that feeds the serial input `X` of the `state_pattern` sequence detector. It accepts a WIDTH-bit word through a load/ready handshake and shifts it out one bit at a time. Each bit is held for BIT_CYCLES clocks. Back-to-back words produce a gap-free bit stream, so patterns that span a word boundary still reach the detector intact.

## Interface
- WIDTH, default 8: bits per word; legal range WIDTH ≥ 2.
- BIT_CYCLES, default 1: clocks each bit is held on `X`; legal range BIT_CYCLES ≥ 1.
- MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- IDLE_BIT, default 0: level driven on `X` when no word is being sent.
- clk  input  1  single system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- data_in  input  WIDTH  word to serialize; sampled only when a load is accepted.
- load  input  1  word-valid request.
- ready  output  1  combinational from registered state; 1 means a load will be accepted this edge.
- X  output  1  registered serial bit, connected to the detector's `X`.
- bit_valid  output  1  registered; 1 while `X` carries a data bit.
- frame_done  output  1  registered one-clock pulse marking the final clock of a word's last bit.

## Operation
- Registered state:
  - state: IDLE or SHIFT.
  - shift register: WIDTH bits.
  - bit counter: clog2(WIDTH) bits, counts 0..WIDTH-1.
  - cycle counter: clog2(BIT_CYCLES) bits, minimum 1 bit, counts 0..BIT_CYCLES-1.
- Reset (`reset`=0 at an edge):
  - state=IDLE, counters=0, shift register=0.
  - X=IDLE_BIT, bit_valid=0, frame_done=0.
  - `ready` is forced 0 while `reset` is low.
- ready = (state==IDLE) OR (state==SHIFT AND bit counter==WIDTH-1 AND cycle counter==BIT_CYCLES-1).
- Accept happens on an edge where load=1 and ready=1:
  - data_in is captured.
  - The first bit (MSB or LSB per MSB_FIRST) is driven on X; bit_valid=1.
  - Both counters are set to 0; state=SHIFT.
- SHIFT, each edge without an accept:
  - If the cycle counter < BIT_CYCLES-1: increment it; hold X.
  - Otherwise, if the bit counter < WIDTH-1: zero the cycle counter, advance the bit counter, shift, and drive the next bit.
  - Otherwise (last clock of the last bit, no new load): state=IDLE, X=IDLE_BIT, bit_valid=0.
- frame_done is 1 exactly during the last clock of the last bit (the same clock in which ready is 1 while in SHIFT).
- Load with ready=0 (mid-word): ignored, not queued; the upstream side must hold `load` until it is accepted.
- Simultaneous accept and end of word: the new word's first bit follows the old word's last bit with no gap; bit_valid stays 1.
- Reset mid-word: the word is aborted, frame_done is not pulsed, and the bits already sent are not replayed.
- data_in changes while in SHIFT have no effect.

## Timing
- Latency: the first bit appears on X in the clock after the accepting edge.
- Word duration: WIDTH×BIT_CYCLES clocks, from the first bit through the last clock of the last bit.
- Back-to-back throughput: one word per WIDTH×BIT_CYCLES clocks, with zero idle clocks.
- First edge after reset release: ready=1 when combinationally evaluated, so a load can be accepted on that edge.
- All outputs are glitch-free registers except `ready`, which is decoded from registers only and never from `load`.

## Test plan
- Reset, then load 8'hDA (WIDTH=8, BIT_CYCLES=1, MSB_FIRST=1):
  - X must read 1,1,0,1,1,0,1,0 over the following 8 clocks; bit_valid=1 for all 8.
  - frame_done must pulse on the 8th clock.
  - The attached detector must raise Z after the 4th and after the 7th bit.
- Back-to-back: hold load=1 with data 8'hF0 then 8'h0F:
  - 16 contiguous valid bits 11110000 00001111, ready=1 only on clocks 8 and 16, no idle bit between words.
- Load pulse while busy: pulse load with 8'hFF on clock 3 of a 8'h00 word:
  - Ignored; X stays 0 for all 8 bits; afterwards X=IDLE_BIT and bit_valid=0.
- BIT_CYCLES=3, word 8'hA5:
  - Each bit is held exactly 3 clocks; the word lasts 24 clocks; frame_done fires on clock 24 only.
- MSB_FIRST=0, word 8'h01:
  - X sequence is 1,0,0,0,0,0,0,0.
- Reset asserted on clock 4 of a word:
  - The next edge gives X=IDLE_BIT, bit_valid=0, frame_done=0, with ready=0 during reset.
  - After release, a new load of 8'h81 serializes correctly from its first bit.

Source files
------------

// File: rtl/pattern_serializer.sv
// pattern_serializer: parallel-to-serial front end for the state_pattern detector.
// Accepts a WIDTH-bit word on a load/ready handshake and shifts it out on X,
// holding every bit for BIT_CYCLES clocks. A load accepted on the last clock of a
// word chains the next word directly behind it, so the bit stream has no gaps.
module pattern_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             X,
  output logic             bit_valid,
  output logic             frame_done
);

  localparam int unsigned BIT_CNT_W = $clog2(WIDTH);
  localparam int unsigned CYC_CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);
  localparam logic [CYC_CNT_W-1:0] LAST_CYC = CYC_CNT_W'(BIT_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     shreg, shreg_n;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [CYC_CNT_W-1:0] cyc_cnt, cyc_cnt_n;
  logic                 x_n, bit_valid_n, frame_done_n;
  logic                 word_end;
  logic                 accept;

  // Last clock of the last bit: the slot where the next word may chain in.
  assign word_end = (state == SHIFT) && (bit_cnt == LAST_BIT) && (cyc_cnt == LAST_CYC);
  assign ready    = reset && ((state == IDLE) || word_end);
  assign accept   = load && ready;

  // Next-state, datapath and output decode.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    cyc_cnt_n   = cyc_cnt;
    x_n         = X;
    bit_valid_n = bit_valid;

    if (accept) begin
      state_n     = SHIFT;
      shreg_n     = data_in;
      bit_cnt_n   = '0;
      cyc_cnt_n   = '0;
      bit_valid_n = 1'b1;
      x_n         = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
    end else if (state == SHIFT) begin
      if (cyc_cnt != LAST_CYC) begin
        cyc_cnt_n = cyc_cnt + CYC_CNT_W'(1);
      end else if (bit_cnt != LAST_BIT) begin
        cyc_cnt_n = '0;
        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
        if (MSB_FIRST) begin
          shreg_n = {shreg[WIDTH-2:0], 1'b0};
          x_n     = shreg[WIDTH-2];
        end else begin
          shreg_n = {1'b0, shreg[WIDTH-1:1]};
          x_n     = shreg[1];
        end
      end else begin
        state_n     = IDLE;
        bit_cnt_n   = '0;
        cyc_cnt_n   = '0;
        x_n         = IDLE_BIT;
        bit_valid_n = 1'b0;
      end
    end

    frame_done_n = (state_n == SHIFT) && (bit_cnt_n == LAST_BIT) && (cyc_cnt_n == LAST_CYC);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      cyc_cnt    <= '0;
      X          <= IDLE_BIT;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      cyc_cnt    <= cyc_cnt_n;
      X          <= x_n;
      bit_valid  <= bit_valid_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: three instances cover the default
// configuration, BIT_CYCLES=3, and LSB-first with a high idle level.
module tb_pattern_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       load_a, load_b, load_c;
  logic       ready_a, x_a, bv_a, fd_a;
  logic       ready_b, x_b, bv_b, fd_b;
  logic       ready_c, x_c, bv_c, fd_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pattern_serializer #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .data_in(data), .load(load_a),
    .ready(ready_a), .X(x_a), .bit_valid(bv_a), .frame_done(fd_a)
  );

  pattern_serializer #(.WIDTH(8), .BIT_CYCLES(3), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .data_in(data), .load(load_b),
    .ready(ready_b), .X(x_b), .bit_valid(bv_b), .frame_done(fd_b)
  );

  pattern_serializer #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_c (
    .clk(clk), .reset(reset), .data_in(data), .load(load_c),
    .ready(ready_c), .X(x_c), .bit_valid(bv_c), .frame_done(fd_c)
  );

  task automatic test_reset();
    reset = 1'b0; load_a = 1'b0; load_b = 1'b0; load_c = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (x_a !== 1'b0)    begin failures++; $display("FAIL reset_x_a got=%b exp=0", x_a); end
    checks++; if (bv_a !== 1'b0)   begin failures++; $display("FAIL reset_bv_a got=%b exp=0", bv_a); end
    checks++; if (fd_a !== 1'b0)   begin failures++; $display("FAIL reset_fd_a got=%b exp=0", fd_a); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL reset_ready_a got=%b exp=0", ready_a); end
    checks++; if (ready_b !== 1'b0) begin failures++; $display("FAIL reset_ready_b got=%b exp=0", ready_b); end
    checks++; if (x_c !== 1'b1)    begin failures++; $display("FAIL reset_x_c_idle got=%b exp=1", x_c); end
    reset = 1'b1;
    #1;
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL release_ready_a got=%b exp=1", ready_a); end
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hDA;
    @(negedge clk);
    data = w; load_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++; if (x_a !== w[8-k]) begin failures++; $display("FAIL single_x k=%0d got=%b exp=%b", k, x_a, w[8-k]); end
      checks++; if (bv_a !== 1'b1)  begin failures++; $display("FAIL single_bv k=%0d got=%b exp=1", k, bv_a); end
      checks++; if (fd_a !== (k == 8)) begin failures++; $display("FAIL single_fd k=%0d got=%b exp=%b", k, fd_a, (k == 8)); end
      checks++; if (ready_a !== (k == 8)) begin failures++; $display("FAIL single_ready k=%0d got=%b exp=%b", k, ready_a, (k == 8)); end
      if (k == 1) load_a = 1'b0;
    end
    @(negedge clk);
    checks++; if (x_a !== 1'b0)  begin failures++; $display("FAIL single_idle_x got=%b exp=0", x_a); end
    checks++; if (bv_a !== 1'b0) begin failures++; $display("FAIL single_idle_bv got=%b exp=0", bv_a); end
    checks++; if (fd_a !== 1'b0) begin failures++; $display("FAIL single_idle_fd got=%b exp=0", fd_a); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    s = 16'hF00F;
    data = 8'hF0; load_a = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++; if (x_a !== s[16-k]) begin failures++; $display("FAIL b2b_x k=%0d got=%b exp=%b", k, x_a, s[16-k]); end
      checks++; if (bv_a !== 1'b1)   begin failures++; $display("FAIL b2b_bv k=%0d got=%b exp=1", k, bv_a); end
      checks++; if (ready_a !== (k == 8 || k == 16)) begin failures++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, ready_a, (k == 8 || k == 16)); end
      checks++; if (fd_a !== (k == 8 || k == 16)) begin failures++; $display("FAIL b2b_fd k=%0d got=%b exp=%b", k, fd_a, (k == 8 || k == 16)); end
      if (k == 1)  data = 8'h0F;
      if (k == 16) load_a = 1'b0;
    end
    @(negedge clk);
    checks++; if (bv_a !== 1'b0) begin failures++; $display("FAIL b2b_idle_bv got=%b exp=0", bv_a); end
    checks++; if (x_a !== 1'b0)  begin failures++; $display("FAIL b2b_idle_x got=%b exp=0", x_a); end
  endtask

  task automatic test_busy_load();
    data = 8'h00; load_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++; if (x_a !== 1'b0)  begin failures++; $display("FAIL busy_x k=%0d got=%b exp=0", k, x_a); end
      checks++; if (bv_a !== 1'b1) begin failures++; $display("FAIL busy_bv k=%0d got=%b exp=1", k, bv_a); end
      if (k == 1) load_a = 1'b0;
      if (k == 2) begin data = 8'hFF; load_a = 1'b1; end
      if (k == 3) load_a = 1'b0;
    end
    @(negedge clk);
    checks++; if (x_a !== 1'b0)    begin failures++; $display("FAIL busy_idle_x got=%b exp=0", x_a); end
    checks++; if (bv_a !== 1'b0)   begin failures++; $display("FAIL busy_idle_bv got=%b exp=0", bv_a); end
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL busy_idle_ready got=%b exp=1", ready_a); end
  endtask

  task automatic test_bit_cycles();
    logic [7:0] w;
    w = 8'hA5;
    data = w; load_b = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      checks++; if (x_b !== w[7-(k-1)/3]) begin failures++; $display("FAIL bc3_x k=%0d got=%b exp=%b", k, x_b, w[7-(k-1)/3]); end
      checks++; if (bv_b !== 1'b1) begin failures++; $display("FAIL bc3_bv k=%0d got=%b exp=1", k, bv_b); end
      checks++; if (fd_b !== (k == 24)) begin failures++; $display("FAIL bc3_fd k=%0d got=%b exp=%b", k, fd_b, (k == 24)); end
      if (k == 1) load_b = 1'b0;
    end
    @(negedge clk);
    checks++; if (bv_b !== 1'b0) begin failures++; $display("FAIL bc3_idle_bv got=%b exp=0", bv_b); end
    checks++; if (fd_b !== 1'b0) begin failures++; $display("FAIL bc3_idle_fd got=%b exp=0", fd_b); end
  endtask

  task automatic test_lsb_first();
    data = 8'h01; load_c = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++; if (x_c !== (k == 1)) begin failures++; $display("FAIL lsb_x k=%0d got=%b exp=%b", k, x_c, (k == 1)); end
      checks++; if (bv_c !== 1'b1) begin failures++; $display("FAIL lsb_bv k=%0d got=%b exp=1", k, bv_c); end
      checks++; if (fd_c !== (k == 8)) begin failures++; $display("FAIL lsb_fd k=%0d got=%b exp=%b", k, fd_c, (k == 8)); end
      if (k == 1) load_c = 1'b0;
    end
    @(negedge clk);
    checks++; if (x_c !== 1'b1)  begin failures++; $display("FAIL lsb_idle_x got=%b exp=1", x_c); end
    checks++; if (bv_c !== 1'b0) begin failures++; $display("FAIL lsb_idle_bv got=%b exp=0", bv_c); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    w = 8'hDA;
    data = w; load_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (x_a !== w[8-k]) begin failures++; $display("FAIL abort_x k=%0d got=%b exp=%b", k, x_a, w[8-k]); end
      if (k == 1) load_a = 1'b0;
    end
    reset = 1'b0;
    #1;
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL abort_ready_low got=%b exp=0", ready_a); end
    @(negedge clk);
    checks++; if (x_a !== 1'b0)     begin failures++; $display("FAIL abort_x_idle got=%b exp=0", x_a); end
    checks++; if (bv_a !== 1'b0)    begin failures++; $display("FAIL abort_bv got=%b exp=0", bv_a); end
    checks++; if (fd_a !== 1'b0)    begin failures++; $display("FAIL abort_fd got=%b exp=0", fd_a); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b exp=0", ready_a); end
    reset = 1'b1;
    w = 8'h81;
    data = w; load_a = 1'b1;
    #1;
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL abort_release_ready got=%b exp=1", ready_a); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++; if (x_a !== w[8-k]) begin failures++; $display("FAIL relaunch_x k=%0d got=%b exp=%b", k, x_a, w[8-k]); end
      checks++; if (bv_a !== 1'b1)  begin failures++; $display("FAIL relaunch_bv k=%0d got=%b exp=1", k, bv_a); end
      checks++; if (fd_a !== (k == 8)) begin failures++; $display("FAIL relaunch_fd k=%0d got=%b exp=%b", k, fd_a, (k == 8)); end
      if (k == 1) load_a = 1'b0;
    end
    @(negedge clk);
    checks++; if (bv_a !== 1'b0) begin failures++; $display("FAIL relaunch_idle_bv got=%b exp=0", bv_a); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_load();
    test_bit_cycles();
    test_lsb_first();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
